crc_frame_arbiter: RTL and testbench
====================================

# crc_frame_arbiter

Frame-level scheduler that shares one byte-wide CRC engine between two requesting byte streams. It grants one source at a time, round-robin at frame boundaries, and accumulates a parameterised CRC over that source's frame. It then presents the final CRC with source ID and byte count on a valid/ready result port. It sits between framing logic (e.g. two MAC/packet builders) and the checksum consumer, replacing two separate single-step CRC instances.

## Interface
- WIDTH, 32, CRC width, 8..64
- POLY, 'h04C11DB7, generator polynomial (implicit top bit omitted)
- REFLECT_IN, 1, reflect each input byte before update
- XOR_IN, all ones, CRC register init value at frame start
- REFLECT_OUT, 1, reflect final register before output XOR
- XOR_OUT, all ones, value XORed into final result

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s0_data  in  8  source 0 byte
- s0_valid  in  1  source 0 byte valid
- s0_last  in  1  source 0 last byte of frame
- s0_ready  out  1  source 0 byte accepted when valid&ready
- s1_data / s1_valid / s1_last / s1_ready  same as s0 for source 1
- crc_out  out  WIDTH  final CRC
- crc_out_src  out  1  source that produced crc_out
- crc_out_len  out  16  bytes in frame, saturating at 16'hFFFF
- crc_out_err  out  1  frame aborted by timeout (see Configuration)
- crc_out_valid  out  1  result valid
- crc_out_ready  in  1  consumer accepts result

## Operation
- FSM states: IDLE, BUSY, RESULT.
- **IDLE**
  - s*_ready = 0.
  - If any s*_valid: grant a source and go to BUSY.
  - With one valid source, grant that source.
  - With both valid, grant the source != last_grant.
  - On grant: register grant; last_grant <= grant; crc_reg <= XOR_IN; len <= 0.
- **BUSY**
  - Only the granted source's ready = 1; the other source's ready = 0.
  - Each accepted byte:
    - crc_reg <= bytewise CRC update of crc_reg with the byte (reflected when REFLECT_IN), MSB-first, POLY.
    - len <= len+1, saturating at 16'hFFFF.
  - Accepted byte with last = 1:
    - The same cycle's updated CRC goes through reflect (REFLECT_OUT) and XOR_OUT.
    - The result is registered into crc_out along with src, len+1 (saturating) and err = 0.
    - Go to RESULT.
- **RESULT**
  - crc_out_valid = 1; both readies are 0.
  - crc_out, crc_out_src, crc_out_len and crc_out_err stay stable until crc_out_valid&crc_out_ready.
  - Then go to IDLE.
- s*_data/last of a non-granted source are ignored. A frame of one byte (valid&last on the first beat) is legal.
- **Reset** (any time, including mid-frame or mid-RESULT):
  - State goes to IDLE; the partial frame is discarded.
  - last_grant = 1, so source 0 wins the first tie.
  - Reset values: s0_ready = s1_ready = 0, crc_out_valid = 0, crc_out = 0, crc_out_src = 0, crc_out_len = 0, crc_out_err = 0.
- All outputs come from registers. There is no combinational path from inputs to outputs.

## Timing
- **Grant:** the cycle a source's valid is seen in IDLE, the FSM enters BUSY at the next edge. ready is high from that cycle, so the first byte is accepted 1 cycle after the request appears.
- **Throughput:** 1 byte/cycle while in BUSY.
- **Result latency:** crc_out_valid rises the cycle after the last byte is accepted.
- **Result to next grant:** a consumer with ready held high completes RESULT in 1 cycle. Next grant occurs in IDLE the following cycle, giving a minimum frame-to-frame gap of 2 idle cycles on the source side.
- **Fairness:** with both sources continuously requesting, grants alternate 0,1,0,1 on every frame.
- **Source stall:** valid low during BUSY inserts wait cycles. crc_reg and len hold.

## Configuration
- Macro: CRC_ARB_TIMEOUT_EN.
- **Defined:**
  - An 8-bit stall counter clears on every accepted byte and on grant.
  - The counter increments on each BUSY cycle without an accepted byte.
  - When it reaches 255, the frame is aborted and the FSM goes to RESULT with crc_out_err = 1.
  - crc_out holds the finalised partial CRC; crc_out_len holds the bytes accepted so far.
- **Undefined:** BUSY waits indefinitely, no counter is built, and crc_out_err is tied to 0.

## Test plan
- **Check value:** source 0 sends ASCII "123456789" (0x31..0x39, last on 0x39) with default parameters -> one result with crc_out = 32'hCBF43926, src = 0, len = 9, err = 0. valid rises 1 cycle after the 0x39 beat.
- **Single byte:** source 1 sends one byte 0x00 with last -> crc_out = 32'hD202EF8D, src = 1, len = 1.
- **Tie arbitration:** both sources request from reset, each sending "123456789" frames back-to-back, 4 frames each -> grant order 0,1,0,1,... Every result = 32'hCBF43926, and the non-granted ready stays 0 throughout.
- **Backpressure:** hold crc_out_ready = 0 for 10 cycles after the result -> outputs stay stable, no source ready, and exactly one transfer when ready rises.
- **Reset mid-frame:** assert rst after 4 bytes -> all outputs take their reset values next cycle. A full "123456789" resend from source 0 then gives 32'hCBF43926 with len = 9.
- **Timeout** (CRC_ARB_TIMEOUT_EN): source 0 sends 3 bytes then drops valid -> result with err = 1 and len = 3 after 255 stall cycles. Without the macro: no result, ready stays high.

Source files
------------

// File: rtl/crc_frame_arbiter.sv
// Round-robin frame arbiter sharing one byte-wide CRC engine between two sources.
// Optional stall timeout abort is built when CRC_ARB_TIMEOUT_EN is defined.
module crc_frame_arbiter #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] POLY        = WIDTH'('h04C11DB7),
  parameter bit               REFLECT_IN  = 1'b1,
  parameter logic [WIDTH-1:0] XOR_IN      = '1,
  parameter bit               REFLECT_OUT = 1'b1,
  parameter logic [WIDTH-1:0] XOR_OUT     = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       s0_data,
  input  logic             s0_valid,
  input  logic             s0_last,
  output logic             s0_ready,
  input  logic [7:0]       s1_data,
  input  logic             s1_valid,
  input  logic             s1_last,
  output logic             s1_ready,
  output logic [WIDTH-1:0] crc_out,
  output logic             crc_out_src,
  output logic [15:0]      crc_out_len,
  output logic             crc_out_err,
  output logic             crc_out_valid,
  input  logic             crc_out_ready
);

  typedef enum logic [1:0] {IDLE, BUSY, RESULT} state_t;

  function automatic logic [7:0] refl8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] reflw(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = v[WIDTH-1-i];
    return r;
  endfunction

  // MSB-first bytewise update: byte is folded into the top 8 bits, then 8 shifts.
  function automatic logic [WIDTH-1:0] crc_step(input logic [WIDTH-1:0] c,
                                                input logic [7:0] b);
    logic [WIDTH-1:0] r;
    logic [7:0]       d;
    d = REFLECT_IN ? refl8(b) : b;
    r = c;
    r[WIDTH-1 -: 8] = r[WIDTH-1 -: 8] ^ d;
    for (int i = 0; i < 8; i++) r = r[WIDTH-1] ? ((r << 1) ^ POLY) : (r << 1);
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] crc_final(input logic [WIDTH-1:0] c);
    return (REFLECT_OUT ? reflw(c) : c) ^ XOR_OUT;
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] l);
    return (l == 16'hFFFF) ? l : l + 16'd1;
  endfunction

  state_t           r_state;
  logic             r_grant;
  logic             r_last_grant;
  logic             r_s0_ready;
  logic             r_s1_ready;
  logic [WIDTH-1:0] r_crc;
  logic [15:0]      r_len;
  logic [WIDTH-1:0] r_crc_out;
  logic             r_crc_out_src;
  logic [15:0]      r_crc_out_len;
  logic             r_crc_out_valid;

  logic             w_req;
  logic             w_pick;
  logic             w_acc;
  logic [7:0]       w_byte;
  logic             w_last;
  logic [WIDTH-1:0] w_crc_next;
  logic [15:0]      w_len_next;

  assign w_req      = s0_valid | s1_valid;
  assign w_pick     = (s0_valid & s1_valid) ? ~r_last_grant : s1_valid;
  assign w_acc      = (r_s0_ready & s0_valid) | (r_s1_ready & s1_valid);
  assign w_byte     = r_grant ? s1_data : s0_data;
  assign w_last     = r_grant ? s1_last : s0_last;
  assign w_crc_next = crc_step(r_crc, w_byte);
  assign w_len_next = sat_inc(r_len);

  // Accumulator datapath: seeded on grant, advanced on every accepted byte.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && w_req) begin
      r_crc <= XOR_IN;
      r_len <= 16'd0;
    end else if (w_acc) begin
      r_crc <= w_crc_next;
      r_len <= w_len_next;
    end
  end

`ifdef CRC_ARB_TIMEOUT_EN
  logic [7:0] r_stall;
  logic       r_crc_out_err;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_grant         <= 1'b0;
      r_last_grant    <= 1'b1;
      r_s0_ready      <= 1'b0;
      r_s1_ready      <= 1'b0;
      r_crc_out       <= '0;
      r_crc_out_src   <= 1'b0;
      r_crc_out_len   <= 16'd0;
      r_crc_out_valid <= 1'b0;
`ifdef CRC_ARB_TIMEOUT_EN
      r_stall         <= 8'd0;
      r_crc_out_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_grant      <= w_pick;
            r_last_grant <= w_pick;
            r_s0_ready   <= ~w_pick;
            r_s1_ready   <= w_pick;
            r_state      <= BUSY;
`ifdef CRC_ARB_TIMEOUT_EN
            r_stall      <= 8'd0;
`endif
          end
        end
        BUSY: begin
          if (w_acc && w_last) begin
            r_s0_ready      <= 1'b0;
            r_s1_ready      <= 1'b0;
            r_crc_out       <= crc_final(w_crc_next);
            r_crc_out_src   <= r_grant;
            r_crc_out_len   <= w_len_next;
            r_crc_out_valid <= 1'b1;
            r_state         <= RESULT;
`ifdef CRC_ARB_TIMEOUT_EN
            r_crc_out_err   <= 1'b0;
`endif
          end
`ifdef CRC_ARB_TIMEOUT_EN
          else if (w_acc) begin
            r_stall <= 8'd0;
          end else if (r_stall == 8'd254) begin
            // 255th consecutive idle cycle: abort with what has been accumulated.
            r_s0_ready      <= 1'b0;
            r_s1_ready      <= 1'b0;
            r_crc_out       <= crc_final(r_crc);
            r_crc_out_src   <= r_grant;
            r_crc_out_len   <= r_len;
            r_crc_out_err   <= 1'b1;
            r_crc_out_valid <= 1'b1;
            r_stall         <= 8'd255;
            r_state         <= RESULT;
          end else begin
            r_stall <= r_stall + 8'd1;
          end
`endif
        end
        RESULT: begin
          if (crc_out_ready) begin
            r_crc_out_valid <= 1'b0;
            r_state         <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign s0_ready      = r_s0_ready;
  assign s1_ready      = r_s1_ready;
  assign crc_out       = r_crc_out;
  assign crc_out_src   = r_crc_out_src;
  assign crc_out_len   = r_crc_out_len;
  assign crc_out_valid = r_crc_out_valid;
`ifdef CRC_ARB_TIMEOUT_EN
  assign crc_out_err   = r_crc_out_err;
`else
  assign crc_out_err   = 1'b0;
`endif

endmodule

// File: tb/tb_crc_frame_arbiter.sv
// Directed bench for crc_frame_arbiter with CRC-32 reference constants.
module tb_crc_frame_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  s0_data, s1_data;
  logic        s0_valid, s0_last, s0_ready;
  logic        s1_valid, s1_last, s1_ready;
  logic [31:0] crc_out;
  logic        crc_out_src;
  logic [15:0] crc_out_len;
  logic        crc_out_err;
  logic        crc_out_valid;
  logic        crc_out_ready;

  int checks = 0;
  int errors = 0;

  logic [7:0]  q0[$], q1[$];
  bit          l0[$], l1[$];
  logic [31:0] rc[$];
  bit          rs[$], re[$];
  logic [15:0] rl[$];
  int          both_ready = 0;

  crc_frame_arbiter dut (
    .clk(clk), .rst(rst),
    .s0_data(s0_data), .s0_valid(s0_valid), .s0_last(s0_last), .s0_ready(s0_ready),
    .s1_data(s1_data), .s1_valid(s1_valid), .s1_last(s1_last), .s1_ready(s1_ready),
    .crc_out(crc_out), .crc_out_src(crc_out_src), .crc_out_len(crc_out_len),
    .crc_out_err(crc_out_err), .crc_out_valid(crc_out_valid),
    .crc_out_ready(crc_out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed no finish expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pushb(input bit s, input logic [7:0] b, input bit last);
    if (s) begin q1.push_back(b); l1.push_back(last); end
    else   begin q0.push_back(b); l0.push_back(last); end
  endtask

  task automatic pushs(input bit s, input string str, input bit with_last);
    for (int i = 0; i < str.len(); i++)
      pushb(s, str[i], with_last && (i == str.len() - 1));
  endtask

  task automatic clear_all();
    q0.delete(); l0.delete(); q1.delete(); l1.delete();
    rc.delete(); rs.delete(); rl.delete(); re.delete();
  endtask

  // Drives both sources from their queues until the stop condition or cycle bound.
  task automatic run(input int nres, input bit stop_valid, input int stop_acc,
                     input int maxcyc, output int vcyc);
    int  cyc  = 0;
    int  accs = 0;
    bit  done = 0;
    bit  a0, a1, lst;
    vcyc = -1;
    while (!done && cyc < maxcyc) begin
      s0_valid = (q0.size() > 0);
      s0_data  = (q0.size() > 0) ? q0[0] : 8'h00;
      s0_last  = (l0.size() > 0) ? l0[0] : 1'b0;
      s1_valid = (q1.size() > 0);
      s1_data  = (q1.size() > 0) ? q1[0] : 8'h00;
      s1_last  = (l1.size() > 0) ? l1[0] : 1'b0;
      a0  = s0_valid & s0_ready;
      a1  = s1_valid & s1_ready;
      lst = (a0 & s0_last) | (a1 & s1_last);
      if (s0_ready & s1_ready) both_ready++;
      if (crc_out_valid & crc_out_ready) begin
        rc.push_back(crc_out); rs.push_back(crc_out_src);
        rl.push_back(crc_out_len); re.push_back(crc_out_err);
      end
      tick();
      cyc++;
      if (a0) begin void'(q0.pop_front()); void'(l0.pop_front()); accs++; end
      if (a1) begin void'(q1.pop_front()); void'(l1.pop_front()); accs++; end
      if (lst) chk("result_latency", crc_out_valid, 1'b1);
      if (crc_out_valid && vcyc < 0) vcyc = cyc;
      done = (nres > 0 && rc.size() >= nres) || (stop_valid && crc_out_valid) ||
             (stop_acc > 0 && accs >= stop_acc);
    end
    s0_valid = 1'b0; s1_valid = 1'b0; s0_last = 1'b0; s1_last = 1'b0;
    chk("run_bound", {63'd0, done}, 64'd1);
  endtask

  initial begin
    int  vc;
    int  k;
    bit  seen_valid;
    bit  ready_dropped;
    rst = 1'b1;
    s0_data = 8'h00; s0_valid = 1'b0; s0_last = 1'b0;
    s1_data = 8'h00; s1_valid = 1'b0; s1_last = 1'b0;
    crc_out_ready = 1'b1;
    repeat (3) tick();
    chk("rst_s0_ready", s0_ready, 1'b0);
    chk("rst_s1_ready", s1_ready, 1'b0);
    chk("rst_valid", crc_out_valid, 1'b0);
    chk("rst_crc", crc_out, 32'h0);
    chk("rst_src", crc_out_src, 1'b0);
    chk("rst_len", crc_out_len, 16'd0);
    chk("rst_err", crc_out_err, 1'b0);
    rst = 1'b0;
    tick();

    // Check value from source 0.
    clear_all();
    pushs(0, "123456789", 1);
    run(1, 0, 0, 200, vc);
    chk("cv_crc", rc[0], 32'hCBF43926);
    chk("cv_src", rs[0], 1'b0);
    chk("cv_len", rl[0], 16'd9);
    chk("cv_err", re[0], 1'b0);
    chk("cv_valid_cycle", vc, 10);

    // Single zero byte from source 1.
    clear_all();
    pushb(1, 8'h00, 1);
    run(1, 0, 0, 50, vc);
    chk("sb_crc", rc[0], 32'hD202EF8D);
    chk("sb_src", rs[0], 1'b1);
    chk("sb_len", rl[0], 16'd1);
    chk("sb_valid_cycle", vc, 2);

    // Tie arbitration from reset.
    rst = 1'b1; tick(); rst = 1'b0;
    clear_all();
    both_ready = 0;
    for (int f = 0; f < 4; f++) begin
      pushs(0, "123456789", 1);
      pushs(1, "123456789", 1);
    end
    run(8, 0, 0, 600, vc);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("tie_crc%0d", i), rc[i], 32'hCBF43926);
      chk($sformatf("tie_src%0d", i), rs[i], i % 2);
      chk($sformatf("tie_len%0d", i), rl[i], 16'd9);
    end
    chk("tie_both_ready", both_ready, 0);

    // Backpressure on the result port.
    clear_all();
    crc_out_ready = 1'b0;
    pushs(0, "1234", 1);
    run(0, 1, 0, 100, vc);
    for (int i = 0; i < 10; i++) begin
      s1_valid = 1'b1; s1_data = 8'h61; s1_last = 1'b1;
      s0_valid = 1'b1; s0_data = 8'h55; s0_last = 1'b1;
      tick();
      chk("bp_crc", crc_out, 32'h9BE3E0A3);
      chk("bp_len", crc_out_len, 16'd4);
      chk("bp_src", crc_out_src, 1'b0);
      chk("bp_valid", crc_out_valid, 1'b1);
      chk("bp_s0_ready", s0_ready, 1'b0);
      chk("bp_s1_ready", s1_ready, 1'b0);
    end
    s0_valid = 1'b0;
    crc_out_ready = 1'b1;
    tick();
    chk("bp_one_transfer", crc_out_valid, 1'b0);
    clear_all();
    pushb(1, 8'h61, 1);
    run(1, 0, 0, 50, vc);
    chk("bp_next_crc", rc[0], 32'hE8B7BE43);
    chk("bp_next_src", rs[0], 1'b1);
    chk("bp_next_len", rl[0], 16'd1);

    // Reset in the middle of a frame.
    clear_all();
    pushs(0, "123456789", 1);
    run(0, 0, 4, 100, vc);
    rst = 1'b1;
    tick();
    chk("mr_s0_ready", s0_ready, 1'b0);
    chk("mr_s1_ready", s1_ready, 1'b0);
    chk("mr_valid", crc_out_valid, 1'b0);
    chk("mr_crc", crc_out, 32'h0);
    chk("mr_src", crc_out_src, 1'b0);
    chk("mr_len", crc_out_len, 16'd0);
    rst = 1'b0;
    clear_all();
    pushs(0, "123456789", 1);
    run(1, 0, 0, 200, vc);
    chk("mr_resend_crc", rc[0], 32'hCBF43926);
    chk("mr_resend_len", rl[0], 16'd9);
    chk("mr_resend_src", rs[0], 1'b0);

    // Source stalls after three bytes.
    clear_all();
    pushs(0, "123", 0);
    run(0, 0, 3, 100, vc);
    k = 0;
    seen_valid = 1'b0;
    ready_dropped = 1'b0;
`ifdef CRC_ARB_TIMEOUT_EN
    while (!crc_out_valid && k < 300) begin
      tick();
      k++;
    end
    chk("to_cycles", k, 255);
    chk("to_crc", crc_out, 32'h884863D2);
    chk("to_err", crc_out_err, 1'b1);
    chk("to_len", crc_out_len, 16'd3);
    chk("to_src", crc_out_src, 1'b0);
    tick();
    chk("to_consumed", crc_out_valid, 1'b0);
`else
    for (int i = 0; i < 300; i++) begin
      tick();
      if (crc_out_valid) seen_valid = 1'b1;
      if (!s0_ready) ready_dropped = 1'b1;
    end
    chk("nto_no_result", seen_valid, 1'b0);
    chk("nto_ready_held", ready_dropped, 1'b0);
    chk("nto_err", crc_out_err, 1'b0);
`endif
    rst = 1'b1; tick(); rst = 1'b0; tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
